entrada_teclado: RTL and testbench

Input-conditioning stage that sits directly upstream of the `maquina` display/control block. It takes the raw push button and the 4-bit switch bank, synchronises and debounces them, and produces exactly one single-cycle `insere` strobe per accepted press. Each strobe carries a stable, BCD-checked `numero`. Non-decimal switch values are rejected with an `invalido` strobe and are never forwarded.

---
 rtl/entrada_pkg.sv | 18 +
 rtl/sincronizador.sv | 26 ++
 rtl/entrada_teclado.sv | 114 +++++++++++
 tb/tb_entrada_teclado.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entrada_pkg.sv
// rtl/entrada_pkg.sv - shared FSM encoding and constants for the keypad input stage
package entrada_pkg;

  typedef enum logic [1:0] {
    OCIOSO         = 2'b00,
    FILTRA_APERTO  = 2'b01,
    APERTADO       = 2'b10,
    FILTRA_SOLTURA = 2'b11
  } estado_t;

  localparam logic [3:0] MAX_DIGITO       = 4'd9;
  localparam int         DEBOUNCE_DEFAULT = 4;

  function automatic logic digito_valido(input logic [3:0] valor);
    return (valor <= MAX_DIGITO);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// rtl/sincronizador.sv - two-flop synchroniser for asynchronous inputs
module sincronizador #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/entrada_teclado.sv
// rtl/entrada_teclado.sv - debounced button/switch capture producing one strobe per press
// Valid BCD digits raise insere; values above nine raise invalido and are dropped.
module entrada_teclado
  import entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao,
  input  logic [4:1] chaves,
  output logic       insere,
  output logic [4:1] numero,
  output logic       invalido,
  output logic       ocupado
);

  localparam logic [7:0] CNT_ULTIMO = 8'(DEBOUNCE_CYCLES - 1);

  logic [4:0] w_sync;
  logic       w_botao_s;
  logic [3:0] w_chaves_s;

  estado_t    r_estado;
  logic [7:0] r_cnt;
  logic [3:0] r_numero;
  logic       r_insere;
  logic       r_invalido;
  logic       r_ocupado;

  sincronizador #(
    .WIDTH(5)
  ) u_sinc (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    ({botao, chaves}),
    .o_q    (w_sync)
  );

  assign w_botao_s  = w_sync[4];
  assign w_chaves_s = w_sync[3:0];

  // Strobes default low every cycle so each accepted press yields a single pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_cnt      <= 8'd0;
      r_numero   <= 4'b0000;
      r_insere   <= 1'b0;
      r_invalido <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_insere   <= 1'b0;
      r_invalido <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_botao_s) begin
            r_estado  <= FILTRA_APERTO;
            r_cnt     <= 8'd1;
            r_ocupado <= 1'b1;
          end
        end
        FILTRA_APERTO: begin
          if (!w_botao_s) begin
            r_estado  <= OCIOSO;
            r_cnt     <= 8'd0;
            r_ocupado <= 1'b0;
          end else if (r_cnt == CNT_ULTIMO) begin
            r_estado <= APERTADO;
            r_cnt    <= 8'd0;
            if (digito_valido(w_chaves_s)) begin
              r_numero <= w_chaves_s;
              r_insere <= 1'b1;
            end else begin
              r_invalido <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        APERTADO: begin
          if (!w_botao_s) begin
            r_estado <= FILTRA_SOLTURA;
            r_cnt    <= 8'd1;
          end
        end
        FILTRA_SOLTURA: begin
          // A bounce back high returns to APERTADO without a new capture.
          if (w_botao_s) begin
            r_estado <= APERTADO;
            r_cnt    <= 8'd0;
          end else if (r_cnt == CNT_ULTIMO) begin
            r_estado  <= OCIOSO;
            r_cnt     <= 8'd0;
            r_ocupado <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_estado  <= OCIOSO;
          r_cnt     <= 8'd0;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign insere   = r_insere;
  assign invalido = r_invalido;
  assign numero   = r_numero;
  assign ocupado  = r_ocupado;

endmodule

// File: tb/tb_entrada_teclado.sv
// tb/tb_entrada_teclado.sv - directed self-checking bench for entrada_teclado
module tb_entrada_teclado;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       botao  = 1'b0;
  logic [4:1] chaves = 4'b0000;
  logic       insere;
  logic [4:1] numero;
  logic       invalido;
  logic       ocupado;

  int vec    = 0;
  int errs   = 0;
  int n_ins  = 0;
  int n_inv  = 0;
  int n_both = 0;

  entrada_teclado #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .botao   (botao),
    .chaves  (chaves),
    .insere  (insere),
    .numero  (numero),
    .invalido(invalido),
    .ocupado (ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (insere === 1'b1) n_ins++;
    if (invalido === 1'b1) n_inv++;
    if (insere === 1'b1 && invalido === 1'b1) n_both++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int b;
    reset  = 1'b0;
    botao  = 1'b1;
    chaves = 4'b0011;
    step(3);
    vec++;
    if ({insere, invalido, ocupado, numero} !== 7'b0) begin
      errs++;
      $display("FAIL reset_outputs got %b want 0000000", {insere, invalido, ocupado, numero});
    end
    reset = 1'b1;
    b = n_ins;
    step(5);
    vec++;
    if (n_ins !== b) begin
      errs++;
      $display("FAIL reset_early_strobe got %0d want %0d", n_ins, b);
    end
    step(1);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b0011) begin
      errs++;
      $display("FAIL reset_release_press got insere=%b numero=%b want 1 0011", insere, numero);
    end
    botao = 1'b0;
    step(10);
    vec++;
    if (ocupado !== 1'b0 || n_ins !== b + 1) begin
      errs++;
      $display("FAIL reset_release_idle got ocupado=%b strobes=%0d want 0 %0d", ocupado, n_ins - b, 1);
    end
  endtask

  task automatic test_clean_press;
    int b;
    chaves = 4'b0101;
    b = n_ins;
    botao = 1'b1;
    step(5);
    vec++;
    if (insere !== 1'b0 || ocupado !== 1'b1) begin
      errs++;
      $display("FAIL clean_pre_latency got insere=%b ocupado=%b want 0 1", insere, ocupado);
    end
    step(1);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b0101) begin
      errs++;
      $display("FAIL clean_strobe got insere=%b numero=%b want 1 0101", insere, numero);
    end
    step(1);
    vec++;
    if (insere !== 1'b0) begin
      errs++;
      $display("FAIL clean_strobe_width got insere=%b want 0", insere);
    end
    step(13);
    botao = 1'b0;
    step(5);
    vec++;
    if (ocupado !== 1'b1) begin
      errs++;
      $display("FAIL clean_busy_release got ocupado=%b want 1", ocupado);
    end
    step(1);
    vec++;
    if (ocupado !== 1'b0 || n_ins !== b + 1 || numero !== 4'b0101) begin
      errs++;
      $display("FAIL clean_idle got ocupado=%b strobes=%0d numero=%b want 0 1 0101", ocupado, n_ins - b, numero);
    end
  endtask

  task automatic test_bounce_press;
    int   b;
    int   bi;
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    chaves = 4'b1001;
    b = n_ins;
    for (int i = 0; i < 5; i++) begin
      botao = pat[i];
      step(1);
    end
    botao = 1'b1;
    step(5);
    vec++;
    if (n_ins !== b) begin
      errs++;
      $display("FAIL bounce_press_early got %0d strobes want 0", n_ins - b);
    end
    step(1);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b1001) begin
      errs++;
      $display("FAIL bounce_press_strobe got insere=%b numero=%b want 1 1001", insere, numero);
    end
    step(5);
    // release bounce while the press is still accepted
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    b = n_ins;
    bi = n_inv;
    for (int i = 0; i < 5; i++) begin
      botao = pat[i];
      step(1);
    end
    botao = 1'b0;
    step(12);
    vec++;
    if (n_ins !== b || n_inv !== bi || ocupado !== 1'b0) begin
      errs++;
      $display("FAIL bounce_release got ins=%0d inv=%0d ocupado=%b want 0 0 0", n_ins - b, n_inv - bi, ocupado);
    end
    b = n_ins;
    botao = 1'b1;
    step(3);
    botao = 1'b0;
    step(10);
    vec++;
    if (n_ins !== b || n_inv !== bi || ocupado !== 1'b0) begin
      errs++;
      $display("FAIL glitch_3cyc got ins=%0d inv=%0d ocupado=%b want 0 0 0", n_ins - b, n_inv - bi, ocupado);
    end
  endtask

  task automatic test_invalid;
    int b;
    int bi;
    b = n_ins;
    bi = n_inv;
    chaves = 4'b1010;
    botao = 1'b1;
    step(6);
    vec++;
    if (invalido !== 1'b1 || insere !== 1'b0 || numero !== 4'b1001) begin
      errs++;
      $display("FAIL invalid_strobe got inv=%b ins=%b numero=%b want 1 0 1001", invalido, insere, numero);
    end
    step(3);
    botao = 1'b0;
    step(10);
    vec++;
    if (n_inv !== bi + 1 || n_ins !== b) begin
      errs++;
      $display("FAIL invalid_count got inv=%0d ins=%0d want 1 0", n_inv - bi, n_ins - b);
    end
    chaves = 4'b0000;
    botao = 1'b1;
    step(6);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b0000 || invalido !== 1'b0) begin
      errs++;
      $display("FAIL zero_after_invalid got ins=%b numero=%b inv=%b want 1 0000 0", insere, numero, invalido);
    end
    botao = 1'b0;
    step(10);
  endtask

  task automatic test_held_switch;
    int b;
    chaves = 4'b0010;
    b = n_ins;
    botao = 1'b1;
    step(6);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b0010) begin
      errs++;
      $display("FAIL held_first got ins=%b numero=%b want 1 0010", insere, numero);
    end
    step(2);
    chaves = 4'b1000;
    step(10);
    vec++;
    if (n_ins !== b + 1 || numero !== 4'b0010) begin
      errs++;
      $display("FAIL held_change got strobes=%0d numero=%b want 1 0010", n_ins - b, numero);
    end
    botao = 1'b0;
    step(10);
    botao = 1'b1;
    step(6);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b1000) begin
      errs++;
      $display("FAIL held_repress got ins=%b numero=%b want 1 1000", insere, numero);
    end
    botao = 1'b0;
    step(10);
  endtask

  task automatic test_capture_window;
    chaves = 4'b0001;
    botao = 1'b1;
    step(3);
    chaves = 4'b0110;
    step(1);
    chaves = 4'b0100;
    step(2);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b0110) begin
      errs++;
      $display("FAIL capture_window got ins=%b numero=%b want 1 0110", insere, numero);
    end
    botao = 1'b0;
    step(10);
  endtask

  task automatic test_reset_mid;
    int b;
    chaves = 4'b0111;
    b = n_ins;
    botao = 1'b1;
    step(7);
    reset = 1'b0;
    #1;
    vec++;
    if ({insere, invalido, ocupado, numero} !== 7'b0) begin
      errs++;
      $display("FAIL reset_async got %b want 0000000", {insere, invalido, ocupado, numero});
    end
    step(2);
    reset = 1'b1;
    step(5);
    vec++;
    if (n_ins !== b + 1) begin
      errs++;
      $display("FAIL reset_mid_early got strobes=%0d want 1", n_ins - b);
    end
    step(1);
    vec++;
    if (insere !== 1'b1 || numero !== 4'b0111) begin
      errs++;
      $display("FAIL reset_mid_repress got ins=%b numero=%b want 1 0111", insere, numero);
    end
    botao = 1'b0;
    step(10);
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce_press;
    test_invalid;
    test_held_switch;
    test_capture_window;
    test_reset_mid;
    vec++;
    if (n_both !== 0) begin
      errs++;
      $display("FAIL mutual_exclusion got %0d overlapping cycles want 0", n_both);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
